// File: rtl/cp0_if.sv
// cp0_if: groups the CP0 pipeline-facing signals.
//   master: memory/commit stage side (drives requests, mtc0/mfc0, interrupts)
//   slave : cp0_unit side (drives read data, status views, flush/redirect)
// NUM_HW_INT sets the width of interrupt_input (1..6).
interface cp0_if #(
    parameter int NUM_HW_INT = 6
);
    logic                  write_enable_input;
    logic [4:0]            write_address_input;
    logic [4:0]            read_address_input;
    logic [31:0]           data_input;
    logic [NUM_HW_INT-1:0] interrupt_input;
    logic [6:0]            exception_vector_input;
    logic                  eret_input;
    logic [31:0]           current_instruction_address_input;
    logic [31:0]           bad_address_input;
    logic                  is_in_delay_slot_input;
    logic [31:0]           data_output;
    logic [31:0]           status_output;
    logic [31:0]           cause_output;
    logic [31:0]           epc_output;
    logic                  interrupt_pending_output;
    logic                  timer_interrupt_output;
    logic                  exception_flush_output;
    logic [31:0]           exception_pc_output;

    modport master (
        output write_enable_input, write_address_input, read_address_input, data_input,
               interrupt_input, exception_vector_input, eret_input,
               current_instruction_address_input, bad_address_input, is_in_delay_slot_input,
        input  data_output, status_output, cause_output, epc_output,
               interrupt_pending_output, timer_interrupt_output,
               exception_flush_output, exception_pc_output
    );

    modport slave (
        input  write_enable_input, write_address_input, read_address_input, data_input,
               interrupt_input, exception_vector_input, eret_input,
               current_instruction_address_input, bad_address_input, is_in_delay_slot_input,
        output data_output, status_output, cause_output, epc_output,
               interrupt_pending_output, timer_interrupt_output,
               exception_flush_output, exception_pc_output
    );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 with Count prescaler, BadVAddr, interrupt
// pending generation and a parametrised number of hardware interrupt lines.
//
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   bus (slave)    : mtc0/mfc0 access, interrupt lines, exception/ERET
//                    requests from the memory stage, and the Status/Cause/EPC
//                    views, interrupt pending, timer, flush and redirect PC.
//
// Optional feature macro CP0_TIMER_EN: builds the Count/Compare timer; its
// sticky output is ORed into Cause.IP[7]. Without it the timer output is 0.
module cp0_unit #(
    parameter int          NUM_HW_INT   = 6,
    parameter int          COUNT_DIV    = 1,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter logic [31:0] PRID_VALUE   = 32'h004C_0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
    input logic  clock,
    input logic  reset,
    cp0_if.slave bus
);
    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_PRID     = 5'd15;
    localparam logic [4:0] ADDR_CONFIG   = 5'd16;

    localparam logic [7:0] DIV_LAST = 8'(COUNT_DIV - 1);

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_BD   = 31;

    function automatic logic [4:0] exc_code_of(input int idx);
        case (idx)
            0:       return 5'd0;   // INT
            1:       return 5'd4;   // AdEL
            2:       return 5'd5;   // AdES
            3:       return 5'd8;   // Sys
            4:       return 5'd10;  // RI
            5:       return 5'd12;  // Ov
            default: return 5'd13;  // Trap
        endcase
    endfunction

    logic [31:0] count_q, compare_q, status_q, cause_q, epc_q, badvaddr_q;
    logic [7:0]  prescaler_q;
`ifdef CP0_TIMER_EN
    logic        timer_q;
`endif

    logic [31:0] status_next, cause_next, epc_next, cause_value;
    logic [4:0]  exc_code;
    logic [5:0]  ip_hw;
    logic        exc_any, wr_count, wr_compare, exl;

    assign exc_any    = |bus.exception_vector_input;
    assign exl        = status_q[STATUS_EXL];
    assign wr_count   = bus.write_enable_input && (bus.write_address_input == ADDR_COUNT);
    assign wr_compare = bus.write_enable_input && (bus.write_address_input == ADDR_COMPARE);

    // Walk from the lowest priority upward so the lowest set index is kept.
    always_comb begin
        exc_code = 5'd0;
        for (int i = 6; i >= 0; i--) begin
            if (bus.exception_vector_input[i]) exc_code = exc_code_of(i);
        end
    end

    // Hardware lines land at IP[2 +: NUM_HW_INT]; unused lines stay 0.
    always_comb begin
        ip_hw = '0;
        ip_hw[NUM_HW_INT-1:0] = bus.interrupt_input;
    end

    always_comb begin
        cause_value = cause_q;
`ifdef CP0_TIMER_EN
        cause_value[15] = cause_q[15] | timer_q;
`endif
    end

    // Software write first, then exception/ERET overrides the bits it owns.
    always_comb begin
        status_next = status_q;
        if (bus.write_enable_input && bus.write_address_input == ADDR_STATUS)
            status_next = bus.data_input;
        if (exc_any)
            status_next[STATUS_EXL] = 1'b1;
        else if (bus.eret_input)
            status_next[STATUS_EXL] = 1'b0;

        epc_next = epc_q;
        if (bus.write_enable_input && bus.write_address_input == ADDR_EPC)
            epc_next = bus.data_input;
        if (exc_any && !exl)
            epc_next = bus.is_in_delay_slot_input ? bus.current_instruction_address_input - 32'd4
                                                  : bus.current_instruction_address_input;

        cause_next = cause_q;
        cause_next[15:10] = ip_hw;
        if (bus.write_enable_input && bus.write_address_input == ADDR_CAUSE) begin
            cause_next[9:8]   = bus.data_input[9:8];
            cause_next[23:22] = bus.data_input[23:22];
        end
        if (exc_any) begin
            cause_next[6:2] = exc_code;
            if (!exl) cause_next[CAUSE_BD] = bus.is_in_delay_slot_input;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= '0;
            compare_q   <= '0;
            status_q    <= 32'h1000_0000;
            cause_q     <= '0;
            epc_q       <= '0;
            badvaddr_q  <= '0;
            prescaler_q <= '0;
`ifdef CP0_TIMER_EN
            timer_q     <= 1'b0;
`endif
        end else begin
            if (wr_count) begin
                count_q     <= bus.data_input;
                prescaler_q <= '0;
            end else if (prescaler_q == DIV_LAST) begin
                count_q     <= count_q + 32'd1;
                prescaler_q <= '0;
            end else begin
                prescaler_q <= prescaler_q + 8'd1;
            end

            if (wr_compare) compare_q <= bus.data_input;

`ifdef CP0_TIMER_EN
            // A Compare write acknowledges the timer and beats a same-cycle match.
            if (wr_compare)
                timer_q <= 1'b0;
            else if (compare_q != 32'd0 && count_q == compare_q)
                timer_q <= 1'b1;
`endif

            status_q <= status_next;
            cause_q  <= cause_next;
            epc_q    <= epc_next;

            if (exc_any && (exc_code == 5'd4 || exc_code == 5'd5))
                badvaddr_q <= bus.bad_address_input;
        end
    end

    always_comb begin
        case (bus.read_address_input)
            ADDR_BADVADDR: bus.data_output = badvaddr_q;
            ADDR_COUNT:    bus.data_output = count_q;
            ADDR_COMPARE:  bus.data_output = compare_q;
            ADDR_STATUS:   bus.data_output = status_q;
            ADDR_CAUSE:    bus.data_output = cause_value;
            ADDR_EPC:      bus.data_output = epc_q;
            ADDR_PRID:     bus.data_output = PRID_VALUE;
            ADDR_CONFIG:   bus.data_output = CONFIG_VALUE;
            default:       bus.data_output = 32'd0;
        endcase
    end

    assign bus.status_output = status_q;
    assign bus.cause_output  = cause_value;
    assign bus.epc_output    = epc_q;
    assign bus.interrupt_pending_output = status_q[STATUS_IE] & ~status_q[STATUS_EXL]
                                        & (|(cause_value[15:8] & status_q[15:8]));
`ifdef CP0_TIMER_EN
    assign bus.timer_interrupt_output = timer_q;
`else
    assign bus.timer_interrupt_output = 1'b0;
`endif
    assign bus.exception_flush_output = exc_any | bus.eret_input;
    assign bus.exception_pc_output    = exc_any        ? EXC_VECTOR :
                                        bus.eret_input ? epc_q      : 32'd0;
endmodule
